// File: rtl/ans_freq_table.sv
// Symbol-statistics table for the rANS decoder: loads per-symbol counts, builds
// inclusive cumulative sums on the fly, and answers PMF/CMF lookups and ICMF scans.
module ans_freq_table #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           tbl_clear,
  input  logic [CNT_WIDTH-1:0]           freq_in,
  input  logic                           freq_vld,
  output logic                           freq_rdy,
  output logic                           loaded,
  input  logic [1:0]                     read_type,
  input  logic [CNT_WIDTH+SYM_WIDTH-1:0] read_query,
  output logic [CNT_WIDTH+SYM_WIDTH-1:0] read_result,
  output logic                           read_rdy,
  output logic                           tbl_err
);

  localparam int W         = CNT_WIDTH + SYM_WIDTH;
  localparam int SYM_COUNT = 2 ** SYM_WIDTH;
  localparam logic [SYM_WIDTH-1:0] LAST_SYM = SYM_WIDTH'(SYM_COUNT - 1);

  localparam logic [1:0] RT_NONE = 2'd0;
  localparam logic [1:0] RT_PMF  = 2'd1;
  localparam logic [1:0] RT_CMF  = 2'd2;
  localparam logic [1:0] RT_ICMF = 2'd3;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_IDLE,
    ST_SCAN,
    ST_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [SYM_WIDTH-1:0] idx_q, idx_d;
  logic                 freq_rdy_q, freq_rdy_d;
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;
  logic [W-1:0]         result_q, result_d;
  logic                 valid_q, valid_d;
  logic [1:0]           type_q, type_d;
  logic [W-1:0]         query_q, query_d;

  logic [CNT_WIDTH-1:0] pmf_q [SYM_COUNT];
  logic [W-1:0]         cmf_q [SYM_COUNT];

  logic                 wr_en;
  logic                 tbl_clr;
  logic [W-1:0]         wr_cmf;
  logic [SYM_WIDTH-1:0] rd_sym;

  state_t               dec_state;
  logic                 dec_valid;
  logic [W-1:0]         dec_result;

  assign rd_sym = read_query[SYM_WIDTH-1:0];
  assign wr_cmf = ((idx_q == '0) ? '0 : cmf_q[idx_q - 1'b1]) + W'(freq_in);

  // Decode of the request currently on the read port, shared by IDLE and the
  // "request changed while holding" path in HOLD.
  always_comb begin
    dec_state  = ST_IDLE;
    dec_valid  = 1'b0;
    dec_result = result_q;
    unique case (read_type)
      RT_PMF: begin
        dec_state  = ST_HOLD;
        dec_valid  = 1'b1;
        dec_result = W'(pmf_q[rd_sym]);
      end
      RT_CMF: begin
        dec_state  = ST_HOLD;
        dec_valid  = 1'b1;
        dec_result = cmf_q[rd_sym];
      end
      RT_ICMF: dec_state = ST_SCAN;
      RT_NONE: dec_state = ST_IDLE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    freq_rdy_d = freq_rdy_q;
    loaded_d   = loaded_q;
    err_d      = err_q;
    result_d   = result_q;
    valid_d    = valid_q;
    type_d     = type_q;
    query_d    = query_q;
    wr_en      = 1'b0;
    tbl_clr    = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        freq_rdy_d = 1'b1;
        if (freq_vld && freq_rdy_q) begin
          wr_en = 1'b1;
          if (idx_q == LAST_SYM) begin
            state_d    = ST_IDLE;
            loaded_d   = 1'b1;
            freq_rdy_d = 1'b0;
            idx_d      = '0;
            err_d      = err_q | (wr_cmf == '0);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (read_type != RT_NONE) begin
          state_d  = dec_state;
          valid_d  = dec_valid;
          result_d = dec_result;
          type_d   = read_type;
          query_d  = read_query;
          idx_d    = '0;
        end
      end
      ST_SCAN: begin
        // Zero-count symbols never satisfy the strict compare, so they are skipped.
        if (cmf_q[idx_q] > query_q) begin
          result_d = W'(idx_q);
          valid_d  = 1'b1;
          state_d  = ST_HOLD;
          idx_d    = '0;
        end else if (idx_q == LAST_SYM) begin
          result_d = W'(LAST_SYM);
          valid_d  = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_HOLD;
          idx_d    = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (read_type == RT_NONE) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if ((read_type != type_q) || (read_query != query_q)) begin
          state_d  = dec_state;
          valid_d  = dec_valid;
          result_d = dec_result;
          type_d   = read_type;
          query_d  = read_query;
          idx_d    = '0;
        end
      end
    endcase

    if (tbl_clear) begin
      tbl_clr    = 1'b1;
      wr_en      = 1'b0;
      state_d    = ST_LOAD;
      idx_d      = '0;
      freq_rdy_d = 1'b1;
      loaded_d   = 1'b0;
      err_d      = 1'b0;
      result_d   = '0;
      valid_d    = 1'b0;
      type_d     = RT_NONE;
      query_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      freq_rdy_q <= 1'b0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      type_q     <= RT_NONE;
      query_q    <= '0;
    end else if (ena) begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      freq_rdy_q <= freq_rdy_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      type_q     <= type_d;
      query_q    <= query_d;
    end
  end

  // Table entries live in flops so a clear or reset wipes the whole table at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYM_COUNT; i++) begin
        pmf_q[i] <= '0;
        cmf_q[i] <= '0;
      end
    end else if (ena) begin
      if (tbl_clr) begin
        for (int i = 0; i < SYM_COUNT; i++) begin
          pmf_q[i] <= '0;
          cmf_q[i] <= '0;
        end
      end else if (wr_en) begin
        pmf_q[idx_q] <= freq_in;
        cmf_q[idx_q] <= wr_cmf;
      end
    end
  end

  assign freq_rdy    = freq_rdy_q;
  assign loaded      = loaded_q;
  assign read_result = result_q;
  assign tbl_err     = err_q;
  // Gated live by the request so the decoder sees 0 as soon as it withdraws or alters it.
  assign read_rdy    = valid_q && (read_type != RT_NONE) &&
                       (read_type == type_q) && (read_query == query_q);

endmodule

// File: tb/tb_ans_freq_table.sv
// Randomized scoreboard bench for ans_freq_table: a driver issues table loads and
// queries, a monitor pops expected results from a queue whenever read_rdy rises.
module tb_ans_freq_table;

  localparam int SW = 4;
  localparam int CW = 8;
  localparam int W  = 12;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b1;
  logic          tbl_clear = 1'b0;
  logic [CW-1:0] freq_in = '0;
  logic          freq_vld = 1'b0;
  logic          freq_rdy;
  logic          loaded;
  logic [1:0]    read_type = 2'd0;
  logic [W-1:0]  read_query = '0;
  logic [W-1:0]  read_result;
  logic          read_rdy;
  logic          tbl_err;

  ans_freq_table #(.SYM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .tbl_clear(tbl_clear),
    .freq_in(freq_in), .freq_vld(freq_vld), .freq_rdy(freq_rdy), .loaded(loaded),
    .read_type(read_type), .read_query(read_query), .read_result(read_result),
    .read_rdy(read_rdy), .tbl_err(tbl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  bit   done = 1'b0;
  bit   prev_rdy = 1'b0;
  int   freq_m[N];
  bit   err_m = 1'b0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: PMF is the count, CMF the inclusive prefix sum, ICMF the first
  // symbol whose inclusive sum exceeds the slot (miss -> last symbol + error).
  task automatic model_req(int t, int q, output exp_t e);
    int sum;
    bit found;
    sum   = 0;
    found = 1'b0;
    e.lat = 1;
    e.res = '0;
    if (t == 1) begin
      e.res = W'(freq_m[q % N]);
    end else if (t == 2) begin
      for (int i = 0; i <= q % N; i++) sum += freq_m[i];
      e.res = W'(sum);
    end else begin
      for (int i = 0; i < N; i++) begin
        sum += freq_m[i];
        if (!found && sum > q) begin
          found = 1'b1;
          e.res = W'(i);
          e.lat = 2 + i;
        end
      end
      if (!found) begin
        e.res = W'(N - 1);
        e.lat = 1 + N;
        err_m = 1'b1;
      end
    end
    e.err = err_m;
  endtask

  // Monitor: one comparison set per rising read_rdy.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (read_rdy && !prev_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_rdy", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", int'(read_result), int'(e.res));
          check("err", int'(tbl_err), int'(e.err));
          check("latency", cyc - issue_cyc, e.lat);
          $display("txn result=%0d err=%0d lat=%0d", read_result, tbl_err, cyc - issue_cyc);
        end
        done = 1'b1;
      end
      prev_rdy = read_rdy;
    end
  end

  task automatic req(int t, int q);
    exp_t e;
    int n;
    n = 0;
    model_req(t, q, e);
    sb.push_back(e);
    @(negedge clk);
    read_type  = t[1:0];
    read_query = q[W-1:0];
    issue_cyc  = cyc;
    done       = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check($sformatf("timeout_type%0d_q%0d", t, q), 0, 1);
      sb.delete();
    end
    read_type = 2'd0;
    #1;
    check("rdy_drop", int'(read_rdy), 0);
  endtask

  task automatic load(int nb);
    int n;
    int sum;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      freq_in  = CW'(freq_m[i]);
      freq_vld = 1'b1;
      n = 0;
      while (!freq_rdy && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!freq_rdy) check("freq_rdy_wait", 0, 1);
    end
    @(negedge clk);
    freq_vld = 1'b0;
    if (nb == N) begin
      sum = 0;
      for (int i = 0; i < N; i++) sum += freq_m[i];
      if (sum == 0) err_m = 1'b1;
      $display("txn load sum=%0d loaded=%0d freq_rdy=%0d err=%0d", sum, loaded, freq_rdy, tbl_err);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    tbl_clear = 1'b1;
    @(negedge clk);
    tbl_clear = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic set_fixed();
    for (int i = 0; i < N; i++) freq_m[i] = 0;
    freq_m[0] = 3;
    freq_m[1] = 1;
    freq_m[3] = 4;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_freq_rdy"}, int'(freq_rdy), 0);
    check({tag, "_loaded"}, int'(loaded), 0);
    check({tag, "_result"}, int'(read_result), 0);
    check({tag, "_read_rdy"}, int'(read_rdy), 0);
    check({tag, "_tbl_err"}, int'(tbl_err), 0);
  endtask

  initial begin
    int tot;
    int t;
    int q;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("freq_rdy_rise", int'(freq_rdy), 1);

    // Directed table {3,1,0,4,0..}
    set_fixed();
    load(N);
    check("load_loaded", int'(loaded), 1);
    check("load_freq_rdy", int'(freq_rdy), 0);
    check("load_err", int'(tbl_err), 0);
    req(2, 15);
    req(2, 1);
    req(1, 3);
    req(3, 0);
    req(3, 3);
    req(3, 4);
    req(3, 7);
    req(3, 8);

    // Random table and random queries
    do_clear();
    check("clear_err", int'(tbl_err), 0);
    check("clear_loaded", int'(loaded), 0);
    tot = 0;
    for (int i = 0; i < N; i++) begin
      freq_m[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      tot += freq_m[i];
    end
    load(N);
    check("rand_loaded", int'(loaded), 1);
    check("rand_err", int'(tbl_err), int'(err_m));
    for (int k = 0; k < 30; k++) begin
      t = int'($urandom_range(1, 3));
      q = (t == 3) ? int'($urandom_range(0, tot)) : int'($urandom_range(0, N - 1));
      req(t, q);
    end

    // Clear in the middle of an ICMF scan
    do_clear();
    set_fixed();
    load(N);
    @(negedge clk);
    read_type  = 2'd3;
    read_query = 12'd7;
    repeat (2) @(negedge clk);
    tbl_clear = 1'b1;
    @(negedge clk);
    tbl_clear = 1'b0;
    err_m = 1'b0;
    check("midscan_loaded", int'(loaded), 0);
    check("midscan_freq_rdy", int'(freq_rdy), 1);
    for (int k = 0; k < 4; k++) begin
      check("midscan_rdy", int'(read_rdy), 0);
      @(negedge clk);
    end
    read_type = 2'd0;

    // All-zero table
    for (int i = 0; i < N; i++) freq_m[i] = 0;
    load(N);
    check("zero_loaded", int'(loaded), 1);
    check("zero_err", int'(tbl_err), 1);
    req(3, 0);
    req(2, 15);

    // Async reset mid-load, then full reload
    do_clear();
    set_fixed();
    load(5);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("midload_rst");
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(N);
    check("reload_loaded", int'(loaded), 1);
    req(2, 15);
    req(1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
